// File: rtl/game_sequencer.sv
// Opcode sequencer for one game plate: arbitrates player commands into a FIFO,
// injects gravity and hard-drop MoveDowns, runs Commit/Check/New and keeps score.
module game_sequencer #(
    parameter int num_src_p       = 2,
    parameter int fifo_depth_p    = 4,
    parameter int gravity_width_p = 24,
    parameter int height_p        = 32,
    parameter int score_width_p   = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [gravity_width_p-1:0]    gravity_period_i,
    input  logic [num_src_p-1:0][2:0]     src_cmd_i,
    input  logic [num_src_p-1:0]          src_v_i,
    output logic [num_src_p-1:0]          src_yumi_o,
    output logic [2:0]                    opcode_o,
    output logic                          opcode_v_o,
    input  logic                          plate_done_i,
    input  logic                          plate_blocked_i,
    input  logic                          plate_lose_i,
    input  logic [$clog2(height_p)-1:0]   line_elim_i,
    input  logic                          line_elim_v_i,
    output logic [score_width_p-1:0]      score_o,
    output logic [score_width_p-1:0]      lines_o,
    output logic [$clog2(fifo_depth_p):0] fifo_count_o,
    output logic                          busy_o,
    output logic                          lost_o
);

    localparam int PtrW  = $clog2(fifo_depth_p);
    localparam int CntW  = PtrW + 1;
    localparam int ElimW = $clog2(height_p);

    typedef enum logic [2:0] {
        eNew       = 3'd0,
        eMoveLeft  = 3'd1,
        eMoveRight = 3'd2,
        eMoveDown  = 3'd3,
        eRotate    = 3'd4,
        eCommit    = 3'd5,
        eCheck     = 3'd6
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_NEW, S_READY, S_WAIT, S_COMMIT, S_CHECK, S_LOST
    } state_e;

    localparam logic [2:0] CmdLeft  = 3'd1;
    localparam logic [2:0] CmdRight = 3'd2;
    localparam logic [2:0] CmdDown  = 3'd3;
    localparam logic [2:0] CmdRot   = 3'd4;
    localparam logic [2:0] CmdHard  = 3'd5;

    function automatic logic is_legal(input logic [2:0] cmd);
        return (cmd >= CmdLeft) && (cmd <= CmdHard);
    endfunction

    function automatic opcode_e cmd_to_op(input logic [2:0] cmd);
        case (cmd)
            CmdLeft:  return eMoveLeft;
            CmdRight: return eMoveRight;
            CmdRot:   return eRotate;
            default:  return eMoveDown;
        endcase
    endfunction

    function automatic logic [score_width_p-1:0] sat_add(input logic [score_width_p-1:0] a,
                                                         input logic [score_width_p-1:0] b);
        logic [score_width_p:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[score_width_p] ? '1 : sum[score_width_p-1:0];
    endfunction

    function automatic logic [score_width_p-1:0] elim_points(input logic [ElimW-1:0] n);
        case (n)
            ElimW'(0): return score_width_p'(0);
            ElimW'(1): return score_width_p'(1);
            ElimW'(2): return score_width_p'(3);
            ElimW'(3): return score_width_p'(5);
            default:   return score_width_p'(8);
        endcase
    endfunction

    state_e                     state_q, state_d;
    opcode_e                    last_op_q, last_op_d, issue_op;
    logic                       issue;
    logic [2:0]                 mem_q [fifo_depth_p];
    logic [PtrW-1:0]            rd_q, wr_q;
    logic [CntW-1:0]            count_q;
    logic [gravity_width_p-1:0] grav_cnt_q, grav_period;
    logic                       grav_pend_q, grav_consume;
    logic                       hd_q, hd_set, hd_clr;
    logic [score_width_p-1:0]   score_q, lines_q;
    logic                       active, lose_now, flush, pop_full, arb_en;
    logic                       push, pop, avail;
    logic [2:0]                 push_cmd, head_cmd;
    logic [num_src_p-1:0]       leg_oh, any_oh;
    logic                       leg_any, any_v;

    assign active      = (state_q != S_IDLE) && (state_q != S_LOST);
    assign lose_now    = plate_lose_i &&
                         (((state_q == S_WAIT) && plate_done_i) ||
                          (active && (state_q != S_WAIT)));
    assign flush       = lose_now || (state_q == S_LOST);
    assign grav_period = (gravity_period_i == '0) ? gravity_width_p'(1) : gravity_period_i;

    // Pop-when-full is derived without looking at push so arbitration has no comb loop.
    assign pop_full = (state_q == S_READY) && !lose_now && !hd_q && !grav_pend_q &&
                      (count_q != '0);
    assign arb_en   = active && !lose_now &&
                      ((count_q != CntW'(fifo_depth_p)) || pop_full);

    always_comb begin
        leg_oh     = '0;
        any_oh     = '0;
        leg_any    = 1'b0;
        any_v      = 1'b0;
        push_cmd   = '0;
        src_yumi_o = '0;
        push       = 1'b0;
        for (int i = num_src_p - 1; i >= 0; i--) begin
            if (src_v_i[i]) begin
                any_oh    = '0;
                any_oh[i] = 1'b1;
                any_v     = 1'b1;
                if (is_legal(src_cmd_i[i])) begin
                    leg_oh    = '0;
                    leg_oh[i] = 1'b1;
                    leg_any   = 1'b1;
                    push_cmd  = src_cmd_i[i];
                end
            end
        end
        if (arb_en) begin
            if (leg_any) begin
                src_yumi_o = leg_oh;
                push       = 1'b1;
            end else if (any_v) begin
                src_yumi_o = any_oh;
            end
        end
    end

    // An empty FIFO with a push this cycle forwards the pushed command directly.
    assign avail    = (count_q != '0) || push;
    assign head_cmd = (count_q != '0) ? mem_q[rd_q] : push_cmd;

    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        issue_op     = last_op_q;
        pop          = 1'b0;
        hd_set       = 1'b0;
        hd_clr       = 1'b0;
        grav_consume = 1'b0;
        if (lose_now) begin
            state_d = S_LOST;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) state_d = S_NEW;
                S_NEW: begin
                    issue    = 1'b1;
                    issue_op = eNew;
                    state_d  = S_WAIT;
                end
                S_READY: begin
                    if (hd_q) begin
                        issue    = 1'b1;
                        issue_op = eMoveDown;
                    end else if (grav_pend_q) begin
                        issue        = 1'b1;
                        issue_op     = eMoveDown;
                        grav_consume = 1'b1;
                    end else if (avail) begin
                        issue    = 1'b1;
                        pop      = 1'b1;
                        issue_op = cmd_to_op(head_cmd);
                        hd_set   = (head_cmd == CmdHard);
                    end
                    if (issue) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (plate_done_i) begin
                        if (last_op_q == eCommit) begin
                            state_d = S_CHECK;
                        end else if (last_op_q == eCheck) begin
                            state_d = S_NEW;
                        end else if ((last_op_q == eMoveDown) && plate_blocked_i) begin
                            hd_clr  = 1'b1;
                            state_d = S_COMMIT;
                        end else begin
                            state_d = S_READY;
                        end
                    end
                end
                S_COMMIT: begin
                    issue    = 1'b1;
                    issue_op = eCommit;
                    state_d  = S_WAIT;
                end
                S_CHECK: begin
                    issue    = 1'b1;
                    issue_op = eCheck;
                    state_d  = S_WAIT;
                end
                S_LOST:  state_d = S_LOST;
                default: state_d = S_IDLE;
            endcase
        end
        last_op_d = issue ? issue_op : last_op_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            last_op_q <= eNew;
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= push_cmd;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grav_cnt_q  <= '0;
            grav_pend_q <= 1'b0;
            hd_q        <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                grav_cnt_q  <= grav_period;
                grav_pend_q <= 1'b0;
            end else if (active) begin
                if (grav_cnt_q <= gravity_width_p'(1)) begin
                    grav_cnt_q  <= grav_period;
                    grav_pend_q <= 1'b1;
                end else begin
                    grav_cnt_q  <= grav_cnt_q - 1'b1;
                    grav_pend_q <= grav_pend_q && !grav_consume;
                end
            end
            if (flush || (state_q == S_IDLE) || hd_clr) hd_q <= 1'b0;
            else if (hd_set)                             hd_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            score_q <= '0;
            lines_q <= '0;
        end else if (line_elim_v_i && (state_q != S_IDLE)) begin
            score_q <= sat_add(score_q, elim_points(line_elim_i));
            lines_q <= sat_add(lines_q, score_width_p'(line_elim_i));
        end
    end

    assign opcode_o     = last_op_d;
    assign opcode_v_o   = issue;
    assign busy_o       = issue || (state_q == S_WAIT);
    assign lost_o       = (state_q == S_LOST);
    assign fifo_count_o = count_q;
    assign score_o      = score_q;
    assign lines_o      = lines_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: opcode sequencing, FIFO, gravity, hard drop, scoring, lose.
module tb_game_sequencer;

    localparam logic [2:0] OP_NEW = 3'd0, OP_L = 3'd1, OP_R = 3'd2, OP_D = 3'd3,
                           OP_ROT = 3'd4, OP_COMMIT = 3'd5, OP_CHECK = 3'd6;

    logic             clk = 1'b0;
    logic             reset_i, start_i;
    logic [23:0]      gravity_period_i;
    logic [1:0][2:0]  src_cmd_i;
    logic [1:0]       src_v_i, src_yumi_o;
    logic [2:0]       opcode_o;
    logic             opcode_v_o, plate_done_i, plate_blocked_i, plate_lose_i;
    logic [4:0]       line_elim_i;
    logic             line_elim_v_i;
    logic [15:0]      score_o, lines_o;
    logic [2:0]       fifo_count_o;
    logic             busy_o, lost_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .gravity_period_i(gravity_period_i), .src_cmd_i(src_cmd_i), .src_v_i(src_v_i),
        .src_yumi_o(src_yumi_o), .opcode_o(opcode_o), .opcode_v_o(opcode_v_o),
        .plate_done_i(plate_done_i), .plate_blocked_i(plate_blocked_i),
        .plate_lose_i(plate_lose_i), .line_elim_i(line_elim_i),
        .line_elim_v_i(line_elim_v_i), .score_o(score_o), .lines_o(lines_o),
        .fifo_count_o(fifo_count_o), .busy_o(busy_o), .lost_o(lost_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Plate reports done (optionally blocked); the following cycle is checked for an issue.
    task automatic finish_op(input logic blk, input logic exp_v, input logic [2:0] exp_op,
                             input string tag);
        plate_done_i    = 1'b1;
        plate_blocked_i = blk;
        tick();
        plate_done_i    = 1'b0;
        plate_blocked_i = 1'b0;
        settle();
        chk({tag, "_v"}, 32'(opcode_v_o), 32'(exp_v));
        if (exp_v) chk({tag, "_op"}, 32'(opcode_o), 32'(exp_op));
    endtask

    task automatic wait_issue(input int limit, output int cycles);
        cycles = 0;
        while (!opcode_v_o && cycles < limit) begin
            tick();
            settle();
            cycles++;
        end
    endtask

    task automatic pulse_elim(input logic [4:0] n);
        line_elim_i   = n;
        line_elim_v_i = 1'b1;
        tick();
        line_elim_v_i = 1'b0;
        settle();
    endtask

    initial begin
        int cyc;
        logic saw_issue;
        reset_i = 1'b1; start_i = 1'b0; gravity_period_i = 24'hFFFFFF;
        src_cmd_i = '0; src_v_i = '0; plate_done_i = 1'b0; plate_blocked_i = 1'b0;
        plate_lose_i = 1'b0; line_elim_i = '0; line_elim_v_i = 1'b0;
        tick(); tick(); settle();
        chk("rst_v", 32'(opcode_v_o), 0);
        chk("rst_op", 32'(opcode_o), 32'(OP_NEW));
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_lost", 32'(lost_o), 0);
        chk("rst_count", 32'(fifo_count_o), 0);
        chk("rst_score", 32'(score_o), 0);
        chk("rst_lines", 32'(lines_o), 0);
        reset_i = 1'b0;
        tick();

        // IDLE: no arbitration, no scoring
        src_v_i = 2'b01; src_cmd_i[0] = 3'd1; line_elim_i = 5'd4; line_elim_v_i = 1'b1;
        settle();
        chk("idle_yumi", 32'(src_yumi_o), 0);
        tick();
        src_v_i = '0; line_elim_v_i = 1'b0;
        settle();
        chk("idle_score", 32'(score_o), 0);
        chk("idle_count", 32'(fifo_count_o), 0);

        // start -> New, done three cycles after the issue
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        settle();
        chk("new_v", 32'(opcode_v_o), 1);
        chk("new_op", 32'(opcode_o), 32'(OP_NEW));
        chk("new_busy", 32'(busy_o), 1);
        tick(); settle();
        chk("wait_v", 32'(opcode_v_o), 0);
        chk("wait_busy", 32'(busy_o), 1);
        tick(); tick(); settle();
        chk("done_busy", 32'(busy_o), 1);
        finish_op(1'b0, 1'b0, OP_NEW, "ready_idle");
        chk("ready_busy", 32'(busy_o), 0);

        // empty FIFO forwards a command pushed in READY
        src_v_i = 2'b01; src_cmd_i[0] = 3'd4;
        settle();
        chk("byp_yumi", 32'(src_yumi_o), 1);
        chk("byp_v", 32'(opcode_v_o), 1);
        chk("byp_op", 32'(opcode_o), 32'(OP_ROT));
        tick();
        src_v_i = 2'b11; src_cmd_i[0] = 3'd1; src_cmd_i[1] = 3'd2;
        settle();
        chk("arb_pri", 32'(src_yumi_o), 1);
        chk("arb_wait_v", 32'(opcode_v_o), 0);
        tick();
        src_v_i = 2'b10;
        settle();
        chk("arb_cnt1", 32'(fifo_count_o), 1);
        chk("arb_src1", 32'(src_yumi_o), 2);
        tick();
        src_v_i = '0;
        settle();
        chk("arb_cnt2", 32'(fifo_count_o), 2);
        finish_op(1'b0, 1'b1, OP_L, "fifo_l");
        tick();
        finish_op(1'b0, 1'b1, OP_R, "fifo_r");
        tick();
        finish_op(1'b0, 1'b0, OP_NEW, "drain_idle");
        chk("drain_cnt", 32'(fifo_count_o), 0);

        // illegal command is accepted and dropped
        src_v_i = 2'b01; src_cmd_i[0] = 3'd7;
        settle();
        chk("ill_yumi", 32'(src_yumi_o), 1);
        chk("ill_v", 32'(opcode_v_o), 0);
        tick();
        src_v_i = '0;
        settle();
        chk("ill_cnt", 32'(fifo_count_o), 0);

        // plate stalls: FIFO fills to 4 and the 5th command is refused
        src_v_i = 2'b01; src_cmd_i[0] = 3'd4;
        settle();
        chk("fill_first_op", 32'(opcode_o), 32'(OP_ROT));
        for (int i = 0; i < 4; i++) begin
            tick();
            src_cmd_i[0] = (i % 2 == 0) ? 3'd1 : 3'd2;
            settle();
            chk("fill_yumi", 32'(src_yumi_o), 1);
        end
        tick(); settle();
        chk("full_cnt", 32'(fifo_count_o), 4);
        chk("full_yumi", 32'(src_yumi_o), 0);
        src_v_i = '0;
        finish_op(1'b0, 1'b1, OP_L, "full_pop1");
        tick();
        finish_op(1'b0, 1'b1, OP_R, "full_pop2");
        tick();
        finish_op(1'b0, 1'b1, OP_L, "full_pop3");
        tick();
        finish_op(1'b0, 1'b1, OP_R, "full_pop4");
        tick();
        finish_op(1'b0, 1'b0, OP_NEW, "full_idle");

        // hard drop, blocked on the third MoveDown
        src_v_i = 2'b01; src_cmd_i[0] = 3'd5;
        settle();
        chk("hd_yumi", 32'(src_yumi_o), 1);
        chk("hd1_op", 32'(opcode_o), 32'(OP_D));
        tick();
        src_v_i = '0;
        finish_op(1'b0, 1'b1, OP_D, "hd2");
        tick();
        finish_op(1'b0, 1'b1, OP_D, "hd3");
        tick();
        finish_op(1'b1, 1'b1, OP_COMMIT, "hd_commit");
        tick();
        finish_op(1'b0, 1'b1, OP_CHECK, "hd_check");
        tick();
        finish_op(1'b0, 1'b1, OP_NEW, "hd_new");
        tick();
        finish_op(1'b0, 1'b0, OP_NEW, "hd_end");

        // scoring
        pulse_elim(5'd4);
        pulse_elim(5'd4);
        chk("sc_4x2", 32'(score_o), 16);
        chk("ln_4x2", 32'(lines_o), 8);
        pulse_elim(5'd1);
        pulse_elim(5'd3);
        chk("sc_1_3", 32'(score_o), 22);
        chk("ln_1_3", 32'(lines_o), 12);
        pulse_elim(5'd2);
        pulse_elim(5'd0);
        pulse_elim(5'd7);
        chk("sc_2_0_7", 32'(score_o), 33);
        chk("ln_2_0_7", 32'(lines_o), 21);

        // gravity with period 10 from a fresh start
        reset_i = 1'b1; gravity_period_i = 24'd10;
        tick(); settle();
        chk("rst2_score", 32'(score_o), 0);
        reset_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        settle();
        chk("g_new_op", 32'(opcode_o), 32'(OP_NEW));
        tick(); tick(); tick();
        finish_op(1'b0, 1'b0, OP_NEW, "g_ready");
        wait_issue(20, cyc);
        chk("g_first_gap", 32'(cyc), 6);
        chk("g_first_op", 32'(opcode_o), 32'(OP_D));
        for (int i = 0; i < 12; i++) tick();
        finish_op(1'b0, 1'b1, OP_D, "g_pend_in_wait");
        tick();
        finish_op(1'b0, 1'b0, OP_NEW, "g_idle");
        wait_issue(20, cyc);
        chk("g_second_gap", 32'(cyc), 5);
        chk("g_second_op", 32'(opcode_o), 32'(OP_D));

        // lose while waiting, with commands queued
        tick();
        src_v_i = 2'b01; src_cmd_i[0] = 3'd1;
        tick(); tick();
        src_v_i = '0;
        settle();
        chk("lose_pre_cnt", 32'(fifo_count_o), 2);
        plate_done_i = 1'b1; plate_lose_i = 1'b1;
        tick();
        plate_done_i = 1'b0; plate_lose_i = 1'b0;
        settle();
        chk("lost", 32'(lost_o), 1);
        chk("lost_cnt", 32'(fifo_count_o), 0);
        chk("lost_busy", 32'(busy_o), 0);
        src_v_i = 2'b01;
        settle();
        chk("lost_yumi", 32'(src_yumi_o), 0);
        saw_issue = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (opcode_v_o) saw_issue = 1'b1;
        end
        src_v_i = '0;
        chk("lost_no_issue", 32'(saw_issue), 0);
        chk("lost_sticky", 32'(lost_o), 1);

        // saturation of both counters
        line_elim_i = 5'd31; line_elim_v_i = 1'b1;
        for (int i = 0; i < 8200; i++) tick();
        line_elim_v_i = 1'b0;
        settle();
        chk("sc_sat", 32'(score_o), 32'hFFFF);
        chk("ln_sat", 32'(lines_o), 32'hFFFF);

        // asynchronous reset
        #2 reset_i = 1'b1;
        #1;
        chk("arst_lost", 32'(lost_o), 0);
        chk("arst_score", 32'(score_o), 0);
        chk("arst_lines", 32'(lines_o), 0);
        chk("arst_v", 32'(opcode_v_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
